// File: rtl/uart_pkg.sv
// Shared types and constants for the USART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        NINTH,
        STOP,
        BRK
    } uart_tx_state_t;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_BREAK_BITS_DEFAULT = 12;

endpackage

// File: rtl/uart_tx_ctrl.sv
// USART async transmitter: TXREG buffer, TSR shifter and frame sequencer.
// Optional break-frame support is enabled with the UART_TX_SENDB_EN macro.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BREAK_BITS = UART_BREAK_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txen,
    input  logic       tx9,
    input  logic       tx9d,
    input  logic       txreg_wr_en,
    input  logic [7:0] txreg_in,
    input  logic       uart_tx_shift_en,
`ifdef UART_TX_SENDB_EN
    input  logic       sendb,
    output logic       sendb_done,
`endif
    output logic       tx_pin,
    output logic       txif,
    output logic       trmt
);

    localparam int CNT_W = $clog2(BREAK_BITS > UART_DATA_BITS ? BREAK_BITS : UART_DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(UART_DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_BRK  = CNT_W'(BREAK_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] txreg_q, txreg_d;
    logic                      txreg_full_q, txreg_full_d;
    logic [UART_DATA_BITS-1:0] tsr_q, tsr_d;
    logic                      tsr9_q, tsr9_d;
    logic                      frame9_q, frame9_d;
    logic                      brk_q, brk_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic                      tx_pin_q, tx_pin_d;
    logic                      txen_prev_q, txen_prev_d;
    logic                      do_load;
    logic                      sendb_w;
`ifdef UART_TX_SENDB_EN
    logic                      sendb_done_q, sendb_done_d;

    assign sendb_w    = sendb;
    assign sendb_done = sendb_done_q;
`else
    assign sendb_w    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        txreg_d     = txreg_in;
        txreg_full_d = txreg_full_q;
        tsr_d       = tsr_q;
        tsr9_d      = tsr9_q;
        frame9_d    = frame9_q;
        brk_d       = brk_q;
        bit_cnt_d   = bit_cnt_q;
        tx_pin_d    = tx_pin_q;
        txen_prev_d = txen;
        do_load     = 1'b0;
`ifdef UART_TX_SENDB_EN
        sendb_done_d = 1'b0;
`endif
        if (!txreg_wr_en) begin
            txreg_d = txreg_q;
        end

        // Dropping txen aborts the frame at once; a coincident shift pulse is ignored.
        if (!txen) begin
            state_d  = IDLE;
            tx_pin_d = 1'b1;
            tsr_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (txreg_full_q) begin
                        do_load = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (uart_tx_shift_en) begin
                        tx_pin_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = brk_q ? BRK : START;
                    end
                end
                START: begin
                    if (uart_tx_shift_en) begin
                        tx_pin_d  = tsr_q[0];
                        tsr_d     = tsr_q >> 1;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (uart_tx_shift_en) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            tx_pin_d = frame9_q ? tsr9_q : 1'b1;
                            state_d  = frame9_q ? NINTH : STOP;
                        end else begin
                            tx_pin_d  = tsr_q[0];
                            tsr_d     = tsr_q >> 1;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                NINTH: begin
                    if (uart_tx_shift_en) begin
                        tx_pin_d = 1'b1;
                        state_d  = STOP;
                    end
                end
                STOP: begin
                    // A waiting byte starts on the stop-bit boundary with no idle bit.
                    if (uart_tx_shift_en) begin
                        if (txreg_full_q) begin
                            do_load   = 1'b1;
                            tx_pin_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = sendb_w ? BRK : START;
                        end else begin
                            tx_pin_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
                BRK: begin
                    if (uart_tx_shift_en) begin
                        if (bit_cnt_q == LAST_BRK) begin
                            tx_pin_d = 1'b1;
                            state_d  = STOP;
`ifdef UART_TX_SENDB_EN
                            sendb_done_d = 1'b1;
`endif
                        end else begin
                            tx_pin_d  = 1'b0;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_load) begin
            tsr_d    = txreg_q;
            tsr9_d   = tx9d;
            frame9_d = tx9;
            brk_d    = sendb_w;
        end

        // A write wins over both the transfer clear and the txen-drop clear.
        if (txen_prev_q && !txen) begin
            txreg_full_d = 1'b0;
        end
        if (do_load) begin
            txreg_full_d = 1'b0;
        end
        if (txreg_wr_en) begin
            txreg_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            txreg_q      <= '0;
            txreg_full_q <= 1'b0;
            tsr_q        <= '0;
            tsr9_q       <= 1'b0;
            frame9_q     <= 1'b0;
            brk_q        <= 1'b0;
            bit_cnt_q    <= '0;
            tx_pin_q     <= 1'b1;
            txen_prev_q  <= 1'b0;
`ifdef UART_TX_SENDB_EN
            sendb_done_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            txreg_q      <= txreg_d;
            txreg_full_q <= txreg_full_d;
            tsr_q        <= tsr_d;
            tsr9_q       <= tsr9_d;
            frame9_q     <= frame9_d;
            brk_q        <= brk_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_pin_q     <= tx_pin_d;
            txen_prev_q  <= txen_prev_d;
`ifdef UART_TX_SENDB_EN
            sendb_done_q <= sendb_done_d;
`endif
        end
    end

    assign tx_pin = tx_pin_q;
    assign txif   = ~txreg_full_q;
    assign trmt   = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl; break frames are exercised when UART_TX_SENDB_EN is defined.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int BRK_N = UART_BREAK_BITS_DEFAULT;

    typedef struct packed {
        logic [7:0] d;
        logic       nine_en;
        logic       nine;
        logic       brk;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst, txen, tx9, tx9d, wr, shift;
    logic [7:0] din;
    logic       tx_pin, txif, trmt;
`ifdef UART_TX_SENDB_EN
    logic       sendb, sendb_done;
    int         done_cnt = 0;
    logic       done_pin = 1'b0;
`endif

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_en = 1'b1;

    uart_tx_ctrl #(.BREAK_BITS(BRK_N)) dut (
        .clk              (clk),
        .rst              (rst),
        .txen             (txen),
        .tx9              (tx9),
        .tx9d             (tx9d),
        .txreg_wr_en      (wr),
        .txreg_in         (din),
        .uart_tx_shift_en (shift),
`ifdef UART_TX_SENDB_EN
        .sendb            (sendb),
        .sendb_done       (sendb_done),
`endif
        .tx_pin           (tx_pin),
        .txif             (txif),
        .trmt             (trmt)
    );

    always #5 clk = ~clk;

    // Reference model: the serial image of a frame, LSB first, start bit at index 0.
    function automatic int frame_len(input frame_t f);
        if (f.brk) return BRK_N + 1;
        return f.nine_en ? 11 : 10;
    endfunction

    function automatic logic [15:0] frame_bits(input frame_t f);
        logic [15:0] v;
        v = '0;
        if (f.brk) begin
            v[BRK_N] = 1'b1;
        end else begin
            v[8:1] = f.d;
            if (f.nine_en) begin
                v[9]  = f.nine;
                v[10] = 1'b1;
            end else begin
                v[9] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit push, input bit brk);
        frame_t f;
        f.d = b; f.nine_en = tx9; f.nine = tx9d; f.brk = brk;
        if (push) exp_q.push_back(f);
        din = b;
        wr  = 1'b1;
        @(negedge clk);
        wr  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int b;
        b = budget;
        while (!(trmt && txif && exp_q.size() == 0) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) timeout_fail(name);
    endtask

    // Bit-time pulse every 16 clocks, driven on the falling edge.
    initial begin
        int cnt;
        cnt   = 0;
        shift = 1'b0;
        forever begin
            @(negedge clk);
            cnt   = (cnt + 1) % 16;
            shift = (cnt == 0);
        end
    end

`ifdef UART_TX_SENDB_EN
    initial begin
        forever begin
            @(negedge clk);
            if (sendb_done) begin
                done_cnt++;
                done_pin = tx_pin;
            end
        end
    end
`endif

    // Monitor: each falling edge from idle/stop starts a frame, sampled mid-bit.
    initial begin
        logic        prev;
        frame_t      f;
        logic [15:0] got;
        int          n;
        bit          aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !tx_pin) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: actual=start_bit required=idle");
                    prev = tx_pin;
                    continue;
                end
                f       = exp_q.pop_front();
                n       = frame_len(f);
                got     = '0;
                aborted = 1'b0;
                repeat (8) @(negedge clk);
                for (int k = 0; k < n; k++) begin
                    if (!mon_en) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[k] = tx_pin;
                    if (k < n - 1) repeat (16) @(negedge clk);
                end
                if (!aborted) check($sformatf("frame_%02h", f.d), {16'h0, got}, {16'h0, frame_bits(f)});
            end
            prev = tx_pin;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_hi;
        int b;
        rst = 1'b1; txen = 1'b0; tx9 = 1'b0; tx9d = 1'b0; wr = 1'b0; din = 8'h00;
`ifdef UART_TX_SENDB_EN
        sendb = 1'b0;
`endif
        tick(2);
        check("reset_tx_pin", tx_pin, 1);
        check("reset_txif", txif, 1);
        check("reset_trmt", trmt, 1);
        rst  = 1'b0;
        txen = 1'b1;
        tick(3);

        // Plain 8-bit frame; txif low for one cycle before the transfer.
        write_byte(8'hA5, 1, 0);
        check("A5_txif_after_write", txif, 0);
        check("A5_trmt_after_write", trmt, 1);
        tick(1);
        check("A5_txif_after_load", txif, 1);
        check("A5_trmt_after_load", trmt, 0);
        wait_idle("A5_idle", 400);

        // Nine-bit frame; tx9d change after load must not matter.
        tx9 = 1'b1; tx9d = 1'b1;
        write_byte(8'h00, 1, 0);
        tick(3);
        tx9d = 1'b0;
        wait_idle("nine_idle", 400);
        tx9 = 1'b0;

        // Second byte queued mid-frame: back-to-back with no idle bit.
        write_byte(8'h55, 1, 0);
        tick(45);
        write_byte(8'h0F, 1, 0);
        check("b2b_txif_queued", txif, 0);
        cnt_hi = 0;
        b = 400;
        while (!txif && b > 0) begin
            if (trmt) cnt_hi++;
            tick(1);
            b--;
        end
        if (b == 0) timeout_fail("b2b_transfer");
        check("b2b_trmt_high_cycles", cnt_hi, 0);
        check("b2b_start_immediate", tx_pin, 0);
        check("b2b_trmt_at_transfer", trmt, 0);
        wait_idle("b2b_idle", 800);

        // Write coincident with the idle transfer edge.
        write_byte(8'h11, 1, 0);
        write_byte(8'h22, 1, 0);
        check("coincide_txif", txif, 0);
        check("coincide_trmt", trmt, 0);
        wait_idle("coincide_idle", 800);

        // Abort mid-frame by dropping txen.
        mon_en = 1'b0;
        write_byte(8'hC3, 0, 0);
        b = 40;
        while (tx_pin && b > 0) begin
            tick(1);
            b--;
        end
        if (b == 0) timeout_fail("abort_start");
        tick(16 * 4 + 8);
        txen = 1'b0;
        tick(1);
        check("abort_tx_pin", tx_pin, 1);
        check("abort_trmt", trmt, 1);
        check("abort_txif", txif, 1);
        tick(20);
        txen = 1'b1;
        cnt_hi = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (!tx_pin || !trmt) cnt_hi++;
        end
        check("reenable_stays_idle", cnt_hi, 0);
        mon_en = 1'b1;

        // Writes while disabled fill TXREG; the later write overwrites the earlier.
        txen = 1'b0;
        tick(2);
        write_byte(8'h33, 0, 0);
        write_byte(8'h44, 1, 0);
        tick(40);
        check("disabled_txif", txif, 0);
        check("disabled_trmt", trmt, 1);
        check("disabled_tx_pin", tx_pin, 1);
        txen = 1'b1;
        wait_idle("disabled_send_idle", 400);

        // Random frames, each written once TXREG is empty.
        for (int i = 0; i < 20; i++) begin
            tick($urandom_range(0, 40));
            b = 1000;
            while (!txif && b > 0) begin
                tick(1);
                b--;
            end
            if (b == 0) timeout_fail("rand_txif");
            tx9  = 1'($urandom_range(0, 1));
            tx9d = 1'($urandom_range(0, 1));
            write_byte(8'($urandom_range(0, 255)), 1, 0);
        end
        b = 1000;
        while (!txif && b > 0) begin
            tick(1);
            b--;
        end
        wait_idle("rand_idle", 1000);
        tx9 = 1'b0; tx9d = 1'b0;

`ifdef UART_TX_SENDB_EN
        // Break frame: BRK_N zero bits then stop, with a one-cycle done pulse.
        done_cnt = 0;
        sendb = 1'b1;
        write_byte(8'hFF, 1, 1);
        b = 40;
        while (trmt && b > 0) begin
            tick(1);
            b--;
        end
        if (b == 0) timeout_fail("brk_load");
        sendb = 1'b0;
        wait_idle("brk_idle", 600);
        check("brk_done_cycles", done_cnt, 1);
        check("brk_done_at_stop", done_pin, 1);
`endif

        tick(20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
